// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART transmit arbiter and its surroundings.
//
// The slave modport is the arbiter. The master modport is everything else:
// the byte requesters (req/lock/data in, ack/grant back) and the shared
// transmitter (tx_data/strobe in, busy back), plus the status flags.
//
//   iv_req           per-port request, held until acked
//   iv_lock          per-port packet lock, sampled with the byte
//   iv_data          flattened bytes, port k at [k*p_DATA_BITS +: p_DATA_BITS]
//   ov_ack           one-cycle pulse, byte of port k latched
//   ov_grant         one-hot owner of current or locked transfer
//   ov_tx_data       byte to the transmitter
//   o_tx_data_ready  one-cycle strobe to the transmitter
//   i_tx_busy        transmitter busy, accept until frame end
//   o_busy           arbiter active or lock held
//   o_timeout        one-cycle pulse on start timeout
interface uart_tx_arbiter_if #(
  parameter int p_PORTS     = 4,
  parameter int p_DATA_BITS = 8
);
  logic [p_PORTS-1:0]             iv_req;
  logic [p_PORTS-1:0]             iv_lock;
  logic [p_PORTS*p_DATA_BITS-1:0] iv_data;
  logic [p_PORTS-1:0]             ov_ack;
  logic [p_PORTS-1:0]             ov_grant;
  logic [p_DATA_BITS-1:0]         ov_tx_data;
  logic                           o_tx_data_ready;
  logic                           i_tx_busy;
  logic                           o_busy;
  logic                           o_timeout;

  modport master (
    output iv_req, iv_lock, iv_data, i_tx_busy,
    input  ov_ack, ov_grant, ov_tx_data, o_tx_data_ready, o_busy, o_timeout
  );

  modport slave (
    input  iv_req, iv_lock, iv_data, i_tx_busy,
    output ov_ack, ov_grant, ov_tx_data, o_tx_data_ready, o_busy, o_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between p_PORTS byte
// requesters, with optional per-port packet lock and a start timeout.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        uart_tx_arbiter_if.slave (requesters, transmitter, status)
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | free, no transfer in progress (lock may be held)
// WAIT_BUSY | strobe issued, waiting for transmitter accept
// WAIT_DONE | frame in flight, waiting for busy to fall
module uart_tx_arbiter #(
  parameter int p_PORTS         = 4,
  parameter int p_DATA_BITS     = 8,
  parameter int p_START_TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = $clog2(p_PORTS);
  localparam int CW = $clog2(p_START_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(p_START_TIMEOUT - 1);
  localparam logic [PW-1:0] PORT_LAST = PW'(p_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          own_q, own_d;
  logic                   lock_q, lock_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [p_PORTS-1:0]     ack_q, ack_d;
  logic [p_PORTS-1:0]     grant_q, grant_d;
  logic [p_DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                   strobe_q, strobe_d;
  logic                   timeout_q, timeout_d;

  logic                   win_found;
  logic [PW-1:0]          win_idx;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] k);
    return (k == PORT_LAST) ? '0 : k + PW'(1);
  endfunction

  // base + off, wrapped into 0..p_PORTS-1 (off is always < p_PORTS)
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= p_PORTS) s = s - p_PORTS;
    return PW'(s);
  endfunction

  // While a lock is held only the owner is eligible; otherwise scan upward
  // from the round-robin pointer and take the first request found.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    if (lock_q) begin
      win_found = bus.iv_req[own_q];
      win_idx   = own_q;
    end else begin
      for (int i = 0; i < p_PORTS; i++) begin
        if (!win_found && bus.iv_req[wrap_add(ptr_q, i)]) begin
          win_found = 1'b1;
          win_idx   = wrap_add(ptr_q, i);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    strobe_d  = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = WAIT_BUSY;
          ack_d[win_idx]   = 1'b1;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          own_d            = win_idx;
          tx_data_d        = bus.iv_data[win_idx*p_DATA_BITS +: p_DATA_BITS];
          strobe_d         = 1'b1;
          lock_d           = bus.iv_lock[win_idx];
          cnt_d            = '0;
          if (!bus.iv_lock[win_idx]) ptr_d = next_port(win_idx);
        end
      end

      WAIT_BUSY: begin
        // accept takes priority over the timeout on the same edge
        if (bus.i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          lock_d    = 1'b0;
          grant_d   = '0;
          ptr_d     = next_port(own_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_DONE: begin
        if (!bus.i_tx_busy) begin
          state_d = IDLE;
          if (!lock_q) grant_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      own_q     <= '0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      ack_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      strobe_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      lock_q    <= lock_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      strobe_q  <= strobe_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.ov_ack          = ack_q;
  assign bus.ov_grant        = grant_q;
  assign bus.ov_tx_data      = tx_data_q;
  assign bus.o_tx_data_ready = strobe_q;
  assign bus.o_timeout       = timeout_q;
  assign bus.o_busy          = (state_q != IDLE) || lock_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: each phase loads per-port byte lists
// and per-transfer transmitter behaviour, a packet-level model predicts the
// strobe sequence, and a monitor pops/compares on every strobe.
module tb_uart_tx_arbiter;
  localparam int P     = 4;
  localparam int DB    = 8;
  localparam int T     = 16;
  localparam int NEVER = 999;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.p_PORTS(P), .p_DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(.p_PORTS(P), .p_DATA_BITS(DB), .p_START_TIMEOUT(T)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         lk;
    bit         tmo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] pd [P][8];
  bit         pl [P][8];
  int         pn [P];
  int         pi [P];
  int         dly  [64];
  int         blen [64];
  int         ntr = 0;
  int         tx_i = 0;
  bit         tx_auto = 0, tx_active = 0, man_busy = 0, load_req = 0;
  int         mdl_ptr = 0;
  bit         to_pend = 0;
  int         since = 0;
  logic [P-1:0] hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level reference: walk the byte lists with the round-robin and
  // lock rules, pushing the expected strobe sequence.
  task automatic predict();
    int idx [P];
    int rem, locked, t, k;
    exp_t e;
    rem = 0; locked = -1; t = 0;
    for (int i = 0; i < P; i++) begin idx[i] = 0; rem += pn[i]; end
    ntr = rem;
    while (rem > 0) begin
      k = -1;
      if (locked >= 0 && idx[locked] < pn[locked]) k = locked;
      else begin
        for (int j = 0; j < P; j++) begin
          int c;
          c = (mdl_ptr + j) % P;
          if (k < 0 && idx[c] < pn[c]) k = c;
        end
      end
      e.port = k;
      e.data = pd[k][idx[k]];
      e.lk   = pl[k][idx[k]];
      e.tmo  = (dly[t] == NEVER);
      idx[k]++; rem--; t++;
      if (e.tmo || !e.lk) begin locked = -1; mdl_ptr = (k + 1) % P; end
      else locked = k;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_ports();
    for (int k = 0; k < P; k++) pn[k] = 0;
  endtask

  task automatic fill_dly_random();
    for (int i = 0; i < 64; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      dly[i] = $urandom_range(0, 3);
      else if (r < 7) dly[i] = T - 1;
      else if (r < 8) dly[i] = NEVER;
      else            dly[i] = $urandom_range(4, 8);
      blen[i] = $urandom_range(1, 5);
    end
  endtask

  task automatic add_byte(input int k, input logic [7:0] d, input bit lk);
    pd[k][pn[k]] = d;
    pl[k][pn[k]] = lk;
    pn[k]++;
  endtask

  task automatic run_phase(input string name);
    int cyc;
    predict();
    tx_i = 0;
    load_req = 1;
    cyc = 0;
    while (!(exp_q.size() == 0 && tx_i >= ntr && !tx_active && !to_pend)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 4000) begin
        chk({name, "_phase_budget"}, cyc, 0);
        exp_q.delete();
        break;
      end
    end
    repeat (3) @(negedge clk);
    chk({name, "_end_grant"}, bus.ov_grant, 0);
    chk({name, "_end_busy"}, bus.o_busy, 0);
  endtask

  // requesters: sole driver of iv_req/iv_lock/iv_data
  task automatic drive_port(input int k);
    if (pi[k] < pn[k]) begin
      bus.iv_req[k]          = 1'b1;
      bus.iv_lock[k]         = pl[k][pi[k]];
      bus.iv_data[k*DB +: DB] = pd[k][pi[k]];
    end else begin
      bus.iv_req[k]  = 1'b0;
      bus.iv_lock[k] = 1'b0;
    end
  endtask

  initial begin
    bus.iv_req = '0; bus.iv_lock = '0; bus.iv_data = '0;
    forever begin
      @(negedge clk);
      if (load_req) begin
        for (int k = 0; k < P; k++) begin pi[k] = 0; drive_port(k); end
        load_req = 0;
      end else if (rst_n) begin
        for (int k = 0; k < P; k++)
          if (bus.ov_ack[k] && bus.iv_req[k]) begin pi[k]++; drive_port(k); end
      end
    end
  end

  // transmitter model: sole driver of i_tx_busy
  initial begin
    int d, l;
    bit last, b2b;
    b2b = 0;
    bus.i_tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!tx_auto || !rst_n) begin
        bus.i_tx_busy = man_busy;
        b2b = 0;
      end else begin
        if (b2b) begin chk("b2b_strobe", bus.o_tx_data_ready, 1); b2b = 0; end
        if (bus.o_tx_data_ready) begin
          tx_active = 1;
          if (tx_i < ntr) begin d = dly[tx_i]; l = blen[tx_i]; end
          else begin d = 0; l = 1; end
          last = (tx_i >= ntr - 1);
          tx_i++;
          if (d != NEVER) begin
            repeat (d) @(negedge clk);
            bus.i_tx_busy = 1'b1;
            repeat (l) @(negedge clk);
            chk("busy_during_frame", bus.o_busy, 1);
            bus.i_tx_busy = 1'b0;
            @(negedge clk);
            if (last) chk("busy_after_frame", bus.o_busy, 0);
            else b2b = 1;
          end
          tx_active = 0;
        end
      end
    end
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = '0; to_pend = 0;
      end else begin
        since++;
        if (bus.o_tx_data_ready) begin
          chk("timeout_before_next_strobe", to_pend, 0);
          chk("strobe_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack", bus.ov_ack, 32'(1) << e.port);
            chk("tx_data", bus.ov_tx_data, e.data);
            chk("grant", bus.ov_grant, 32'(1) << e.port);
            to_pend = e.tmo;
            since   = 0;
            hold    = (e.lk && !e.tmo) ? P'(1 << e.port) : '0;
          end
        end else begin
          if (bus.ov_ack != 0) chk("ack_without_strobe", bus.ov_ack, 0);
          if (hold != 0) chk("lock_grant_hold", bus.ov_grant, hold);
        end
        if (bus.o_timeout) begin
          chk("timeout_expected", to_pend, 1);
          chk("timeout_latency", since, T);
          chk("timeout_grant", bus.ov_grant, 0);
          to_pend = 0;
        end
      end
    end
  end

  initial begin
    clear_ports();
    fill_dly_random();
    repeat (3) @(negedge clk);
    chk("rst_ack", bus.ov_ack, 0);
    chk("rst_grant", bus.ov_grant, 0);
    chk("rst_tx_data", bus.ov_tx_data, 0);
    chk("rst_strobe", bus.o_tx_data_ready, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    rst_n = 1'b1;
    tx_auto = 1;
    repeat (2) @(negedge clk);

    // fairness: all ports, two rounds
    clear_ports();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < P; k++) add_byte(k, 8'(8'h10 + k), 1'b0);
    fill_dly_random();
    for (int i = 0; i < 8; i++) if (dly[i] == NEVER) dly[i] = 1;
    run_phase("fair");

    // single request, accept after 2, busy for 20
    clear_ports();
    add_byte(0, 8'h5A, 1'b0);
    dly[0] = 2; blen[0] = 20;
    run_phase("single");

    // locked packet on port 2 while port 0 waits
    clear_ports();
    add_byte(2, 8'h21, 1'b1);
    add_byte(2, 8'h22, 1'b1);
    add_byte(2, 8'h23, 1'b0);
    add_byte(0, 8'h05, 1'b0);
    for (int i = 0; i < 4; i++) begin dly[i] = 1; blen[i] = 3; end
    run_phase("lock");

    // timeout on one port, next requester served; accept at last count
    clear_ports();
    add_byte(1, 8'h31, 1'b0);
    add_byte(3, 8'h33, 1'b0);
    dly[0] = NEVER; blen[0] = 1;
    dly[1] = T - 1; blen[1] = 2;
    run_phase("timeout");

    // random phases
    for (int ph = 0; ph < 8; ph++) begin
      int sum;
      clear_ports();
      for (int k = 0; k < P; k++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int i = 0; i < len; i++) add_byte(k, 8'($urandom), i < len - 1);
        end
      end
      sum = 0;
      for (int k = 0; k < P; k++) sum += pn[k];
      if (sum == 0) add_byte($urandom_range(0, P - 1), 8'($urandom), 1'b0);
      fill_dly_random();
      run_phase("rand");
    end

    // busy already high before the strobe
    tx_auto = 0;
    man_busy = 1;
    repeat (3) @(negedge clk);
    clear_ports();
    add_byte(1, 8'h77, 1'b0);
    dly[0] = 0;
    predict();
    load_req = 1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) @(negedge clk);
    chk("pre_busy_strobe", exp_q.size(), 0);
    repeat (T + 8) @(negedge clk);
    chk("pre_busy_still_busy", bus.o_busy, 1);
    man_busy = 0;
    repeat (3) @(negedge clk);
    chk("pre_busy_done", bus.o_busy, 0);
    chk("pre_busy_grant", bus.ov_grant, 0);

    // reset during WAIT_DONE of a locked packet
    clear_ports();
    add_byte(2, 8'hA1, 1'b1);
    add_byte(2, 8'hA2, 1'b0);
    dly[0] = 0; dly[1] = 0;
    predict();
    load_req = 1;
    for (int c = 0; c < 60 && exp_q.size() > 1; c++) @(negedge clk);
    chk("rst_mid_strobe", exp_q.size(), 1);
    man_busy = 1;
    repeat (4) @(negedge clk);
    chk("rst_mid_grant_pre", bus.ov_grant, 4'b0100);
    chk("rst_mid_busy_pre", bus.o_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ack", bus.ov_ack, 0);
    chk("rst_mid_grant", bus.ov_grant, 0);
    chk("rst_mid_tx_data", bus.ov_tx_data, 0);
    chk("rst_mid_strobe_out", bus.o_tx_data_ready, 0);
    chk("rst_mid_busy", bus.o_busy, 0);
    chk("rst_mid_timeout", bus.o_timeout, 0);
    exp_q.delete();
    mdl_ptr = 0;
    man_busy = 0;
    clear_ports();
    load_req = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_auto = 1;
    @(negedge clk);
    clear_ports();
    for (int k = 0; k < P; k++) add_byte(k, 8'(8'hC0 + k), 1'b0);
    fill_dly_random();
    for (int i = 0; i < P; i++) if (dly[i] == NEVER) dly[i] = 2;
    run_phase("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `p_PORTS` byte requesters. It latches a byte from the winning requester, presents it to the transmitter with a one-cycle strobe, and tracks the transmitter's busy flag until the frame ends before granting again. An optional per-port lock holds the grant across a multi-byte packet. A start timeout recovers if the transmitter never accepts a strobe.

## Interface
Parameters:
- `p_PORTS`, 4, number of requesters (2..8).
- `p_DATA_BITS`, 8, byte width. Must match the transmitter.
- `p_START_TIMEOUT`, 16, cycles allowed between strobe and `i_tx_busy` rising (>= 2).

Ports:
- `i_clk`  in  1  system clock. All logic on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `iv_req`  in  `p_PORTS`  per-port request. Held high until acked.
- `iv_lock`  in  `p_PORTS`  per-port packet lock, sampled with the byte.
- `iv_data`  in  `p_PORTS*p_DATA_BITS`  flattened data. Port k occupies `[k*p_DATA_BITS +: p_DATA_BITS]`.
- `ov_ack`  out  `p_PORTS`  one-cycle pulse: byte of port k latched.
- `ov_grant`  out  `p_PORTS`  one-hot owner of the current or locked transfer. 0 when free.
- `ov_tx_data`  out  `p_DATA_BITS`  byte to the transmitter.
- `o_tx_data_ready`  out  1  one-cycle strobe to the transmitter.
- `i_tx_busy`  in  1  transmitter busy, high from accept until frame end.
- `o_busy`  out  1  arbiter not in IDLE, or a lock is held.
- `o_timeout`  out  1  one-cycle pulse on start timeout.

## Operation
- States:
  - IDLE: free, no transfer in progress.
  - WAIT_BUSY: strobe issued, waiting for the transmitter to accept.
  - WAIT_DONE: frame in flight.
- Winner selection: with no lock held, the winner is the first asserted `iv_req` bit searched from pointer `rv_ptr` upward, wrapping modulo `p_PORTS`.
- IDLE → WAIT_BUSY when a winner k exists. On that edge:
  - `ov_ack[k]`=1, `ov_grant`=onehot(k), `ov_tx_data`=byte k, `o_tx_data_ready`=1.
  - The lock flag is set to `iv_lock[k]`.
  - If the lock flag is 0, `rv_ptr` becomes (k+1) mod `p_PORTS`.
- Lock held: only port k is eligible. Other requests wait. The lock releases when port k's byte is accepted with `iv_lock[k]`=0; `rv_ptr` then advances past k.
- WAIT_BUSY:
  - `i_tx_busy`=1 → WAIT_DONE.
  - Otherwise the counter increments. At count `p_START_TIMEOUT`-1 → IDLE with `o_timeout`=1; lock and grant are cleared, and `rv_ptr` advances past k.
- WAIT_DONE → IDLE when `i_tx_busy`=0. `ov_grant` clears unless the lock is held.
- `ov_tx_data` holds its value until the next strobe.
- Requests are level-sensitive. A request that drops before its ack is never served, and no ack is generated for it.
- The counter width is `$clog2(p_START_TIMEOUT)`. The counter clears on entering WAIT_BUSY.

## Timing
- Reset (async, `i_reset_n`=0):
  - All outputs are 0.
  - State is IDLE, `rv_ptr`=0, lock cleared, counter 0.
  - Reset takes effect mid-frame; no ack or strobe is emitted for an interrupted transfer.
- Latency: request seen in IDLE → ack and strobe on the next rising edge (1 cycle).
- `ov_ack` and `o_tx_data_ready` are registered and coincide. Each is exactly one cycle wide.
- Back-to-back bytes: `i_tx_busy` falls at edge n → IDLE at n+1 → next strobe at n+2 if a request is pending.
- `i_tx_busy` already high when the strobe is issued counts as accept on the first WAIT_BUSY cycle.
- Timeout and `i_tx_busy` rising on the same edge: accept wins, no timeout.
- Simultaneous requests on all ports with no lock: service order is `rv_ptr`, `rv_ptr`+1, and so on. Each port gets one byte per round.
- `iv_lock` on a port that is not granted has no effect.

## Test plan
- Single request: `iv_req`=0001, data 0x5A. Transmitter model accepts after 2 cycles, busy for 20 cycles → exactly one ack to port 0, `ov_tx_data`=0x5A, `o_busy` falls 1 cycle after busy falls.
- Fairness: all 4 ports request continuously with data 0x10..0x13 → strobe order 0x10,0x11,0x12,0x13,0x10,… Each port acked once per 4 frames.
- Lock: port 2 sends 3 bytes with `iv_lock`=1,1,0 while port 0 requests → bytes from port 2 strobe consecutively, then port 0. `ov_grant`=0100 throughout the packet.
- Timeout: transmitter model never raises busy, `p_START_TIMEOUT`=16 → `o_timeout` pulses 16 cycles after the strobe, state returns to IDLE, and the next requester is served.
- Reset mid-frame: assert `i_reset_n`=0 during WAIT_DONE of a locked packet → all outputs are 0 immediately. After release, port 0 (`rv_ptr`=0) wins first.
- Busy pre-asserted: `i_tx_busy`=1 before the strobe → goes straight to WAIT_DONE, no timeout, completion on busy fall.
